// File: rtl/trap_ctrl_if.sv
// MEM-stage event, interrupt and CSR-file signals of the trap controller, grouped as one bundle.
// The master side is the pipeline/CSR file; the slave side is trap_ctrl.
interface trap_ctrl_if;
    logic        valid_mem;
    logic [31:0] pc_mem;
    logic [31:0] inst_mem;
    logic [31:0] addr_mem;
    logic        illegal_mem;
    logic        ecall_mem;
    logic        ld_mis_mem;
    logic        st_mis_mem;
    logic        mret_mem;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        trap;
    logic        mret;
    logic [31:0] mepc_in;
    logic [31:0] mcause_in;
    logic [31:0] mtval_in;
    logic        flush_all;
    logic        stall_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output valid_mem, pc_mem, inst_mem, addr_mem,
        output illegal_mem, ecall_mem, ld_mis_mem, st_mis_mem, mret_mem,
        output ext_irq, timer_irq, mstatus, mtvec, mepc,
        input  trap, mret, mepc_in, mcause_in, mtval_in,
        input  flush_all, stall_req, redirect_valid, redirect_pc
    );

    modport slave (
        input  valid_mem, pc_mem, inst_mem, addr_mem,
        input  illegal_mem, ecall_mem, ld_mis_mem, st_mis_mem, mret_mem,
        input  ext_irq, timer_irq, mstatus, mtvec, mepc,
        output trap, mret, mepc_in, mcause_in, mtval_in,
        output flush_all, stall_req, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: selects a MEM-stage event, strobes the CSR file in COMMIT, redirects fetch in REDIRECT.
// Latency: selection -> redirect_valid 2 cycles; no backpressure, events are ignored outside IDLE.
// Optional TRAP_VECTORED_EN: interrupts with mtvec[1:0]=01 vector to base + 4*cause.
module trap_ctrl (
    input  logic         clk,
    input  logic         rst,
    trap_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

    state_t      state, state_nxt;
    logic        ext_q, timer_q;
    logic        ext_pend, timer_pend;
    logic        is_mret_q;
    logic [31:0] mepc_r, mcause_r, mtval_r;
    logic [31:0] shadow_cause, shadow_tval;

    logic        sel, sel_mret, take_ext, take_timer, mie;
    logic [31:0] cause_nxt, tval_nxt, tvec_base, target_pc;

    assign mie = bus.mstatus[3];

    // Fixed-priority event selection, only while idle with a valid MEM instruction.
    always_comb begin
        sel        = 1'b0;
        sel_mret   = 1'b0;
        take_ext   = 1'b0;
        take_timer = 1'b0;
        cause_nxt  = 32'd0;
        tval_nxt   = 32'd0;
        if (state == IDLE && bus.valid_mem) begin
            sel = 1'b1;
            if (bus.illegal_mem) begin
                cause_nxt = 32'd2;
                tval_nxt  = bus.inst_mem;
            end else if (bus.ecall_mem) begin
                cause_nxt = 32'd11;
            end else if (bus.ld_mis_mem) begin
                cause_nxt = 32'd4;
                tval_nxt  = bus.addr_mem;
            end else if (bus.st_mis_mem) begin
                cause_nxt = 32'd6;
                tval_nxt  = bus.addr_mem;
            end else if (bus.mret_mem) begin
                sel_mret = 1'b1;
            end else if (mie && ext_pend) begin
                take_ext  = 1'b1;
                cause_nxt = 32'h8000_000B;
            end else if (mie && timer_pend) begin
                take_timer = 1'b1;
                cause_nxt  = 32'h8000_0007;
            end else begin
                sel = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (sel) state_nxt = COMMIT;
            COMMIT:   state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q        <= 1'b0;
            timer_q      <= 1'b0;
            ext_pend     <= 1'b0;
            timer_pend   <= 1'b0;
            is_mret_q    <= 1'b0;
            mepc_r       <= 32'd0;
            mcause_r     <= 32'd0;
            mtval_r      <= 32'd0;
            shadow_cause <= 32'd0;
            shadow_tval  <= 32'd0;
        end else begin
            ext_q      <= bus.ext_irq;
            timer_q    <= bus.timer_irq;
            // A new edge arriving as the source is taken keeps the bit set.
            ext_pend   <= (ext_pend & ~take_ext) | (bus.ext_irq & ~ext_q);
            timer_pend <= (timer_pend & ~take_timer) | (bus.timer_irq & ~timer_q);
            if (sel) begin
                is_mret_q <= sel_mret;
                if (sel_mret) begin
                    mepc_r   <= bus.mepc;
                    mcause_r <= shadow_cause;
                    mtval_r  <= shadow_tval;
                end else begin
                    mepc_r       <= bus.pc_mem;
                    mcause_r     <= cause_nxt;
                    mtval_r      <= tval_nxt;
                    shadow_cause <= cause_nxt;
                    shadow_tval  <= tval_nxt;
                end
            end
        end
    end

    assign tvec_base = bus.mtvec & ~32'd3;

    always_comb begin
        target_pc = tvec_base;
`ifdef TRAP_VECTORED_EN
        if (mcause_r[31] && bus.mtvec[1:0] == 2'b01)
            target_pc = tvec_base + {mcause_r[29:0], 2'b00};
`else
        target_pc = tvec_base;
`endif
        if (is_mret_q) target_pc = bus.mepc;
    end

    assign bus.trap           = (state == COMMIT) && !is_mret_q;
    assign bus.mret           = (state == COMMIT) &&  is_mret_q;
    assign bus.mepc_in        = mepc_r;
    assign bus.mcause_in      = mcause_r;
    assign bus.mtval_in       = mtval_r;
    assign bus.flush_all      = sel || (state == COMMIT);
    assign bus.stall_req      = (state == COMMIT) || (state == REDIRECT);
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = (state == REDIRECT) ? target_pc : 32'd0;
endmodule
